piso_serializer: RTL and testbench



---
 rtl/piso_serializer.sv | 141 ++++++++++++++
 tb/tb_piso_serializer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in, serial-out shifter: accepts a WIDTH-bit word over valid/ready and
// emits it one bit per clock on sout, with frame_start/done strobes and optional inter-word gap.
module piso_serializer #(
  parameter int WIDTH      = 16,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0,
  parameter int GAP_CYCLES = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  input  logic             din_valid,
  output logic             din_ready,
  output logic             sout,
  output logic             sout_valid,
  output logic             frame_start,
  output logic             done,
  output logic             busy
);

  localparam int                CNT_W    = $clog2(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(WIDTH - 1);
  localparam bit                HAS_GAP  = (GAP_CYCLES > 0);
  localparam logic [3:0]        GAP_LOAD = HAS_GAP ? 4'(GAP_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_GAP   = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_shift;
  logic [WIDTH-1:0]   w_shift_next;
  logic [CNT_W-1:0]   r_bit_cnt;
  logic [CNT_W-1:0]   w_bit_cnt_next;
  logic [3:0]         r_gap_cnt;
  logic [3:0]         w_gap_cnt_next;
  logic               r_sout;
  logic               w_sout_next;
  logic               r_sout_valid;
  logic               w_sout_valid_next;
  logic               r_frame_start;
  logic               w_frame_start_next;
  logic               r_done;
  logic               w_done_next;

  logic [WIDTH-1:0]   w_din_ord;
  logic               w_load;

  // Reorder the input once so the shifter always sends its top bit first.
  generate
    for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
      assign w_din_ord[gi] = MSB_FIRST ? din[gi] : din[WIDTH-1-gi];
    end
  endgenerate

  assign din_ready   = (r_state == ST_IDLE) && !rst;
  assign w_load      = din_valid && din_ready;

  assign sout        = r_sout;
  assign sout_valid  = r_sout_valid;
  assign frame_start = r_frame_start;
  assign done        = r_done;
  assign busy        = (r_state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_shift       <= '0;
      r_bit_cnt     <= '0;
      r_gap_cnt     <= '0;
      r_sout        <= IDLE_LEVEL;
      r_sout_valid  <= 1'b0;
      r_frame_start <= 1'b0;
      r_done        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_shift       <= w_shift_next;
      r_bit_cnt     <= w_bit_cnt_next;
      r_gap_cnt     <= w_gap_cnt_next;
      r_sout        <= w_sout_next;
      r_sout_valid  <= w_sout_valid_next;
      r_frame_start <= w_frame_start_next;
      r_done        <= w_done_next;
    end
  end

  always_comb begin
    w_state_next       = r_state;
    w_shift_next       = r_shift;
    w_bit_cnt_next     = r_bit_cnt;
    w_gap_cnt_next     = r_gap_cnt;
    w_sout_next        = IDLE_LEVEL;
    w_sout_valid_next  = 1'b0;
    w_frame_start_next = 1'b0;
    w_done_next        = 1'b0;

    case (r_state)
      ST_IDLE: begin
        if (w_load) begin
          // First bit goes straight to the output register; the rest wait in r_shift.
          w_state_next       = ST_SHIFT;
          w_sout_next        = w_din_ord[WIDTH-1];
          w_sout_valid_next  = 1'b1;
          w_frame_start_next = 1'b1;
          w_shift_next       = {w_din_ord[WIDTH-2:0], 1'b0};
          w_bit_cnt_next     = CNT_LOAD;
        end
      end
      ST_SHIFT: begin
        if (r_bit_cnt == '0) begin
          w_done_next = 1'b1;
          if (HAS_GAP) begin
            w_state_next   = ST_GAP;
            w_gap_cnt_next = GAP_LOAD;
          end else begin
            w_state_next = ST_IDLE;
          end
        end else begin
          w_sout_next       = r_shift[WIDTH-1];
          w_sout_valid_next = 1'b1;
          w_shift_next      = {r_shift[WIDTH-2:0], 1'b0};
          w_bit_cnt_next    = r_bit_cnt - CNT_W'(1);
        end
      end
      ST_GAP: begin
        if (r_gap_cnt == 4'd0) begin
          w_state_next = ST_IDLE;
        end else begin
          w_gap_cnt_next = r_gap_cnt - 4'd1;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Bench for piso_serializer: two instances (MSB-first/no gap, LSB-first/gap 3) checked
// every cycle against a per-cycle expectation table, plus literal checks on whole frames.
`timescale 1ns/1ps
module tb_piso_serializer;
  localparam int W    = 16;
  localparam int NCYC = 2048;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [1:0]       din_valid_v;
  logic [W-1:0]     din0, din1;
  wire  [1:0]       din_ready_v, sout_v, sout_valid_v, fs_v, done_v, busy_v;

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0), .GAP_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .din(din0), .din_valid(din_valid_v[0]), .din_ready(din_ready_v[0]),
    .sout(sout_v[0]), .sout_valid(sout_valid_v[0]), .frame_start(fs_v[0]), .done(done_v[0]),
    .busy(busy_v[0]));

  piso_serializer #(.WIDTH(W), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b0), .GAP_CYCLES(3)) dut1 (
    .clk(clk), .rst(rst), .din(din1), .din_valid(din_valid_v[1]), .din_ready(din_ready_v[1]),
    .sout(sout_v[1]), .sout_valid(sout_valid_v[1]), .frame_start(fs_v[1]), .done(done_v[1]),
    .busy(busy_v[1]));

  // Expected outputs indexed by cycle number (cycle c = period after the c-th rising edge).
  bit exp_sout  [2][NCYC];
  bit exp_valid [2][NCYC];
  bit exp_fs    [2][NCYC];
  bit exp_done  [2][NCYC];
  bit exp_busy  [2][NCYC];
  int ready_cyc [2];
  int gap_of    [2] = '{0, 3};
  bit msb_of    [2] = '{1'b1, 1'b0};

  int cyc = 0;
  int total = 0;
  int bad = 0;
  bit check_en = 1'b0;

  // Frame capture per instance.
  logic [W-1:0] asm_w [2];
  int           nbits [2];
  int words0[$], words1[$], fs0[$], fs1[$], done0[$], done1[$];

  task automatic chk(input string name, input int c, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, c, act, exp);
    end
  endtask

  function automatic int qget(input int q[$], input int i);
    return (i < q.size()) ? q[i] : -1;
  endfunction

  task automatic clear_cycle(input int d, input int i);
    exp_sout[d][i]  = 1'b0;
    exp_valid[d][i] = 1'b0;
    exp_fs[d][i]    = 1'b0;
    exp_done[d][i]  = 1'b0;
    exp_busy[d][i]  = 1'b0;
  endtask

  // Model: a word accepted at edge e occupies cycles e..e+W-1, done at e+W,
  // and the block is ready again at cycle e+W+gap.
  task automatic model_step();
    int e;
    logic [W-1:0] w;
    e = cyc;
    if (e + W + 20 >= NCYC) return;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int i = e; i < e + 64 && i < NCYC; i++) clear_cycle(d, i);
        ready_cyc[d] = e;
      end else if (din_valid_v[d] && (e - 1) >= ready_cyc[d]) begin
        w = (d == 0) ? din0 : din1;
        for (int k = 0; k < W; k++) begin
          exp_sout[d][e+k]  = msb_of[d] ? w[W-1-k] : w[k];
          exp_valid[d][e+k] = 1'b1;
        end
        exp_fs[d][e]     = 1'b1;
        exp_done[d][e+W] = 1'b1;
        for (int i = e; i < e + W + gap_of[d]; i++) exp_busy[d][i] = 1'b1;
        ready_cyc[d] = e + W + gap_of[d];
      end
    end
  endtask

  task automatic compare_and_capture();
    int c;
    c = cyc;
    if (!check_en || c >= NCYC) return;
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("dut%0d.sout", d),        c, 32'(sout_v[d]),       32'(exp_sout[d][c]));
      chk($sformatf("dut%0d.sout_valid", d),  c, 32'(sout_valid_v[d]), 32'(exp_valid[d][c]));
      chk($sformatf("dut%0d.frame_start", d), c, 32'(fs_v[d]),         32'(exp_fs[d][c]));
      chk($sformatf("dut%0d.done", d),        c, 32'(done_v[d]),       32'(exp_done[d][c]));
      chk($sformatf("dut%0d.busy", d),        c, 32'(busy_v[d]),       32'(exp_busy[d][c]));
      chk($sformatf("dut%0d.din_ready", d),   c, 32'(din_ready_v[d]),
          32'((c >= ready_cyc[d]) && !rst));
      if (fs_v[d] === 1'b1) begin
        asm_w[d] = '0;
        nbits[d] = 0;
        if (d == 0) fs0.push_back(c); else fs1.push_back(c);
      end
      if (done_v[d] === 1'b1) begin
        if (d == 0) done0.push_back(c); else done1.push_back(c);
      end
      if (sout_valid_v[d] === 1'b1) begin
        // dut0 assembles MSB-first; dut1 mimics the receiver chain shifting toward bit0.
        if (d == 0) asm_w[d] = {asm_w[d][W-2:0], sout_v[d]};
        else        asm_w[d] = {sout_v[d], asm_w[d][W-1:1]};
        nbits[d]++;
        if (nbits[d] == W) begin
          if (d == 0) words0.push_back(int'(asm_w[d])); else words1.push_back(int'(asm_w[d]));
        end
      end
    end
  endtask

  task automatic clear_logs();
    words0.delete(); words1.delete(); fs0.delete(); fs1.delete(); done0.delete(); done1.delete();
  endtask

  task automatic send(input int d, input logic [W-1:0] w);
    int budget;
    budget = 0;
    @(negedge clk);
    if (d == 0) din0 = w; else din1 = w;
    din_valid_v[d] = 1'b1;
    #1;
    while (din_ready_v[d] !== 1'b1 && budget < 200) begin
      @(negedge clk);
      #1;
      budget++;
    end
    if (din_ready_v[d] !== 1'b1) begin
      total++;
      bad++;
      $display("FAIL send_timeout dut%0d got=din_ready_low want=accept word=%0h", d, w);
      din_valid_v[d] = 1'b0;
    end else begin
      @(posedge clk);
    end
  endtask

  task automatic drop(input int d);
    @(negedge clk);
    din_valid_v[d] = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NCYC; i++) clear_cycle(d, i);
      ready_cyc[d] = 0;
      nbits[d] = 0;
      asm_w[d] = '0;
    end
    forever begin
      @(posedge clk);
      cyc++;
      model_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      #2;
      compare_and_capture();
    end
  end

  initial begin
    rst = 1'b1;
    din_valid_v = 2'b00;
    din0 = '0;
    din1 = '0;

    // Reset for two cycles, then idle.
    repeat (2) @(posedge clk);
    check_en = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    idle(20);
    chk("t1.no_frames", cyc, 32'(fs0.size() + fs1.size() + done0.size() + done1.size()), 32'd0);

    // Single MSB-first word.
    clear_logs();
    send(0, 16'hA5C3);
    drop(0);
    idle(25);
    chk("t2.word", cyc, 32'(qget(words0, 0)), 32'h0000A5C3);
    chk("t2.nframes", cyc, 32'(fs0.size()), 32'd1);
    chk("t2.done_offset", cyc, 32'(qget(done0, 0) - qget(fs0, 0)), 32'd16);

    // LSB-first word through the receiver chain.
    clear_logs();
    send(1, 16'h0001);
    drop(1);
    idle(25);
    chk("t3.rx_word", cyc, 32'(qget(words1, 0)), 32'h00000001);
    chk("t3.done_offset", cyc, 32'(qget(done1, 0) - qget(fs1, 0)), 32'd16);

    // Back-to-back, no gap.
    clear_logs();
    send(0, 16'hFFFF);
    send(0, 16'h0000);
    drop(0);
    idle(25);
    chk("t4.word0", cyc, 32'(qget(words0, 0)), 32'h0000FFFF);
    chk("t4.word1", cyc, 32'(qget(words0, 1)), 32'h00000000);
    chk("t4.frame_spacing", cyc, 32'(qget(fs0, 1) - qget(fs0, 0)), 32'd17);
    chk("t4.done_spacing", cyc, 32'(qget(done0, 1) - qget(done0, 0)), 32'd17);

    // Back-to-back with a 3-cycle gap.
    clear_logs();
    send(1, 16'h8001);
    send(1, 16'h1234);
    drop(1);
    idle(30);
    chk("t5.word0", cyc, 32'(qget(words1, 0)), 32'h00008001);
    chk("t5.word1", cyc, 32'(qget(words1, 1)), 32'h00001234);
    chk("t5.frame_spacing", cyc, 32'(qget(fs1, 1) - qget(fs1, 0)), 32'd20);
    chk("t5.done_to_next", cyc, 32'(qget(fs1, 1) - qget(done1, 0)), 32'd4);

    // Reset while bit 7 is on the line, then a fresh word.
    clear_logs();
    send(0, 16'h1234);
    repeat (8) @(negedge clk);
    rst = 1'b1;
    din_valid_v[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    idle(5);
    chk("t6.no_done", cyc, 32'(done0.size()), 32'd0);
    chk("t6.no_word", cyc, 32'(words0.size()), 32'd0);
    send(0, 16'h00FF);
    drop(0);
    idle(25);
    chk("t6.word_after", cyc, 32'(qget(words0, 0)), 32'h000000FF);
    chk("t6.nwords", cyc, 32'(words0.size()), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
